// File: rtl/pseudoinverse_sequencer.sv
// pseudoinverse_sequencer: drives an incremental pseudoinverse core one column
// at a time. It latches the source matrix and issues column k with the columns
// before it (masked A). It then waits for the core's endPs edge and feeds that
// result back as the next P. After the last column it publishes the final
// pseudoinverse. A per-column watchdog reports a core that never answers.
//
// Core handshake: coreStart is a one-cycle pulse, with coreA/coreP/coreCol/
// coreDim already valid in that cycle. Those operands stay stable until the
// core raises coreEnd. Only a rising edge of coreEnd seen while waiting counts
// as an answer. A level still high from an earlier column is only ignored if
// the core drops it once it sees the next coreStart.
module pseudoinverse_sequencer #(
    parameter int M       = 4,
    parameter int N       = 4,
    parameter int nBits   = 32,
    parameter int TIMEOUT = 4096
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   go,
    input  logic [M*N*nBits-1:0]   matIn,
    input  logic [nBits-1:0]       nCols,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [nBits-1:0]       colIdx,
    output logic [M*N*nBits-1:0]   PsInvOut,
    output logic [M*N*nBits-1:0]   coreA,
    output logic [M*N*nBits-1:0]   coreP,
    output logic [M*nBits-1:0]     coreCol,
    output logic [nBits-1:0]       coreDim,
    output logic                   coreStart,
    input  logic                   coreEnd,
    input  logic [M*N*nBits-1:0]   coreResult,
    output logic [2:0]             dbg_state
);

    localparam int MW = M * N * nBits;
    localparam int CW = M * nBits;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        NEXT  = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } state_t;

    state_t            state;
    logic [MW-1:0]     mat_q;
    logic [MW-1:0]     p_q;
    logic [nBits-1:0]  nc_q;
    logic [TW-1:0]     timer;
    logic              end_prev;

    logic [nBits-1:0]  clamped_n;
    logic [nBits-1:0]  next_k;
    logic [MW-1:0]     issue_mat;
    logic [nBits-1:0]  issue_k;
    logic              end_edge;

    // Keep only the columns strictly left of kk; everything else reads zero.
    function automatic logic [MW-1:0] mask_cols(input logic [MW-1:0] mat,
                                                input logic [nBits-1:0] kk);
        logic [MW-1:0] r;
        r = '0;
        for (int i = 0; i < M; i++) begin
            for (int j = 0; j < N; j++) begin
                if (nBits'(j) < kk) begin
                    r[(M*N-1-(i*N+j))*nBits +: nBits] = mat[(M*N-1-(i*N+j))*nBits +: nBits];
                end
            end
        end
        return r;
    endfunction

    // Extract column kk as an M-element vector, element 0 in the top word.
    function automatic logic [CW-1:0] pick_col(input logic [MW-1:0] mat,
                                               input logic [nBits-1:0] kk);
        logic [CW-1:0] r;
        r = '0;
        for (int i = 0; i < M; i++) begin
            for (int j = 0; j < N; j++) begin
                if (nBits'(j) == kk) begin
                    r[(M-1-i)*nBits +: nBits] = mat[(M*N-1-(i*N+j))*nBits +: nBits];
                end
            end
        end
        return r;
    endfunction

    assign clamped_n = (nCols > nBits'(N)) ? nBits'(N) : nCols;
    assign next_k    = colIdx + nBits'(1);
    assign end_edge  = coreEnd & ~end_prev;
    assign dbg_state = state;

    // Operands for the next issue: first column straight from the inputs on
    // acceptance, otherwise the following column of the latched matrix.
    always_comb begin
        issue_mat = mat_q;
        issue_k   = next_k;
        if (state == IDLE) begin
            issue_mat = matIn;
            issue_k   = '0;
        end
    end

    // Sequencer FSM; every output is loaded here so all of them are registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            mat_q     <= '0;
            p_q       <= '0;
            nc_q      <= '0;
            timer     <= '0;
            end_prev  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            colIdx    <= '0;
            PsInvOut  <= '0;
            coreA     <= '0;
            coreP     <= '0;
            coreCol   <= '0;
            coreDim   <= '0;
            coreStart <= 1'b0;
        end else begin
            done      <= 1'b0;
            coreStart <= 1'b0;
            case (state)
                IDLE: begin
                    if (go) begin
                        mat_q  <= matIn;
                        nc_q   <= clamped_n;
                        p_q    <= '0;
                        colIdx <= '0;
                        error  <= 1'b0;
                        busy   <= 1'b1;
                        if (clamped_n == '0) begin
                            state <= DONE;
                        end else begin
                            coreA     <= mask_cols(issue_mat, issue_k);
                            coreP     <= '0;
                            coreCol   <= pick_col(issue_mat, issue_k);
                            coreDim   <= issue_k;
                            coreStart <= 1'b1;
                            state     <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    timer    <= '0;
                    end_prev <= 1'b0;
                    state    <= WAIT;
                end
                WAIT: begin
                    end_prev <= coreEnd;
                    if (end_edge) begin
                        p_q   <= coreResult;
                        state <= NEXT;
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        error <= 1'b1;
                        busy  <= 1'b0;
                        state <= ERR;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                NEXT: begin
                    colIdx <= next_k;
                    if (next_k == nc_q) begin
                        state <= DONE;
                    end else begin
                        coreA     <= mask_cols(issue_mat, issue_k);
                        coreP     <= p_q;
                        coreCol   <= pick_col(issue_mat, issue_k);
                        coreDim   <= issue_k;
                        coreStart <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                DONE: begin
                    PsInvOut <= p_q;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                ERR: begin
                    error <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pseudoinverse_sequencer.sv
// Bench for pseudoinverse_sequencer: a behavioural core answers each start
// after a programmable latency with 0x00010000 ^ dim in every word. Runs are
// predicted from the column-sequencing rules and checked through an expected
// queue of column indices.
module tb_pseudoinverse_sequencer;

    localparam int M  = 4;
    localparam int N  = 4;
    localparam int NB = 32;
    localparam int TO = 16;
    localparam int W  = M * N * NB;
    localparam int CW = M * NB;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          rst;
    logic          go;
    logic [W-1:0]  mat_in;
    logic [NB-1:0] n_cols;
    logic          busy, done, error, core_start;
    logic [NB-1:0] col_idx, core_dim;
    logic [W-1:0]  ps_inv_out, core_a, core_p;
    logic [CW-1:0] core_col;
    logic          core_end = 1'b0;
    logic [W-1:0]  core_result = '0;
    logic [2:0]    dbg_state;

    always #5 clk = ~clk;

    pseudoinverse_sequencer #(.M(M), .N(N), .nBits(NB), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(rst), .go(go), .matIn(mat_in), .nCols(n_cols),
        .busy(busy), .done(done), .error(error), .colIdx(col_idx),
        .PsInvOut(ps_inv_out), .coreA(core_a), .coreP(core_p), .coreCol(core_col),
        .coreDim(core_dim), .coreStart(core_start), .coreEnd(core_end),
        .coreResult(core_result), .dbg_state(dbg_state)
    );

    // ---------------- reference data ----------------
    int tests_run = 0;
    int tests_failed = 0;
    logic [NB-1:0] exp_q[$];
    logic [NB-1:0] m_el [M][N];
    logic [W-1:0]  last_ps = '0;
    int            prev_err = 0;

    function automatic logic [W-1:0] fill(input logic [NB-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < M * N; i++) r[i*NB +: NB] = v;
        return r;
    endfunction

    function automatic logic [W-1:0] pack_mat();
        logic [W-1:0] r;
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++)
                r[(M*N-1-(i*N+j))*NB +: NB] = m_el[i][j];
        return r;
    endfunction

    function automatic logic [W-1:0] exp_a(input int k);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < M; i++)
            for (int j = 0; j < k; j++)
                r[(M*N-1-(i*N+j))*NB +: NB] = m_el[i][j];
        return r;
    endfunction

    function automatic logic [CW-1:0] exp_col(input int k);
        logic [CW-1:0] r;
        for (int i = 0; i < M; i++) r[(M-1-i)*NB +: NB] = m_el[i][k];
        return r;
    endfunction

    function automatic logic [W-1:0] exp_p(input int k);
        if (k == 0) return '0;
        return fill(32'h0001_0000 ^ NB'(k - 1));
    endfunction

    function automatic logic [W-1:0] rand_wide();
        logic [W-1:0] r;
        for (int i = 0; i < M * N; i++) r[i*NB +: NB] = $urandom;
        return r;
    endfunction

    // ---------------- behavioural core ----------------
    int            core_lat = 10;
    int            core_hold = 1;
    bit            core_answer = 1'b1;
    int            cnt = 0;
    int            hold_left = 0;
    logic [NB-1:0] pend_dim = '0;
    logic          m_st, m_rst;
    logic [NB-1:0] m_d;

    always @(posedge clk) begin
        m_st  = core_start;
        m_rst = rst;
        m_d   = core_dim;
        #1;
        if (m_rst) begin
            cnt = 0; hold_left = 0; core_end = 1'b0;
        end else if (m_st && core_answer) begin
            cnt = core_lat - 1; pend_dim = m_d; hold_left = 0; core_end = 1'b0;
        end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
                core_result = fill(32'h0001_0000 ^ pend_dim);
                core_end    = 1'b1;
                hold_left   = core_hold - 1;
            end
        end else if (hold_left > 0) begin
            hold_left--;
        end else begin
            core_end = 1'b0;
        end
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check_int(input string name, input longint act, input longint expv);
        tests_run++;
        if (act != expv) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic check_vec(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
        tests_run++;
        if (act !== expv) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_int({tag, ":busy"}, busy, 0);
        check_int({tag, ":done"}, done, 0);
        check_int({tag, ":error"}, error, 0);
        check_int({tag, ":core_start"}, core_start, 0);
        check_int({tag, ":col_idx"}, col_idx, 0);
        check_int({tag, ":core_dim"}, core_dim, 0);
        check_vec({tag, ":ps_inv_out"}, ps_inv_out, '0);
        check_vec({tag, ":core_a"}, core_a, '0);
        check_vec({tag, ":core_p"}, core_p, '0);
        check_vec({tag, ":core_col"}, core_col, '0);
    endtask

    // ---------------- driver: one complete run ----------------
    task automatic run_case(input string name, input logic [NB-1:0] ncols, input int lat,
                            input int hold, input bit answer, input int go_again);
        int nc, exp_starts, exp_done, exp_err, starts, done_cyc, err_cyc, stop_at, k;
        bit fails;
        logic [W-1:0] exp_ps;
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++) m_el[i][j] = $urandom;
        nc         = (ncols > NB'(N)) ? N : int'(ncols);
        fails      = (nc > 0) && (!answer || lat > TO);
        exp_starts = fails ? 1 : nc;
        exp_done   = fails ? -1 : 2 + nc * (lat + 2);
        exp_err    = fails ? 2 + TO : -1;
        if (fails) exp_ps = last_ps;
        else if (nc == 0) exp_ps = '0;
        else exp_ps = fill(32'h0001_0000 ^ NB'(nc - 1));
        exp_q.delete();
        for (int c = 0; c < exp_starts; c++) exp_q.push_back(NB'(c));
        core_lat = lat; core_hold = hold; core_answer = answer;

        @(negedge clk);
        check_int({name, ":error_before_go"}, error, prev_err);
        check_int({name, ":busy_before_go"}, busy, 0);
        mat_in = pack_mat(); n_cols = ncols; go = 1'b1;
        starts = 0; done_cyc = -1; err_cyc = -1; stop_at = 300;
        for (int cyc = 1; cyc <= stop_at; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 1) begin
                go = 1'b0; mat_in = rand_wide(); n_cols = $urandom;
                check_int({name, ":busy_after_go"}, busy, 1);
                check_int({name, ":error_cleared"}, error, 0);
            end
            if (go_again > 0) go = (cyc == go_again);
            if (core_start) begin
                starts++;
                if (exp_q.size() == 0) begin
                    check_int({name, ":extra_start"}, starts, exp_starts);
                end else begin
                    k = int'(exp_q.pop_front());
                    check_int({name, ":core_dim"}, core_dim, k);
                    check_int({name, ":col_idx"}, col_idx, k);
                    check_vec({name, ":core_a"}, core_a, exp_a(k));
                    check_vec({name, ":core_p"}, core_p, exp_p(k));
                    check_vec({name, ":core_col"}, core_col, exp_col(k));
                end
            end
            if (done_cyc > 0 && cyc == done_cyc + 1) check_int({name, ":done_width"}, done, 0);
            if (done && done_cyc < 0) begin
                done_cyc = cyc;
                check_vec({name, ":ps_inv_at_done"}, ps_inv_out, exp_ps);
                check_int({name, ":busy_at_done"}, busy, 0);
                stop_at = cyc + 1;
            end
            if (error && err_cyc < 0) begin
                err_cyc = cyc;
                check_int({name, ":busy_at_error"}, busy, 0);
                stop_at = cyc + 20;
            end
        end
        go = 1'b0;
        check_int({name, ":start_count"}, starts, exp_starts);
        check_int({name, ":done_cycle"}, done_cyc, exp_done);
        check_int({name, ":error_cycle"}, err_cyc, exp_err);
        check_int({name, ":queue_left"}, exp_q.size(), 0);
        check_vec({name, ":ps_inv_final"}, ps_inv_out, exp_ps);
        check_int({name, ":error_final"}, error, fails);
        prev_err = fails;
        if (!fails) last_ps = exp_ps;
        repeat (40) @(posedge clk);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string         name;
        logic [NB-1:0] ncols;
        int            lat;
        int            hold;
        bit            answer;
        int            go_again;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int dones, starts_seen;
        vecs[0]  = '{"two_cols",          32'd2,          10, 1, 1'b1, 0};
        vecs[1]  = '{"zero_cols",         32'd0,          10, 1, 1'b1, 0};
        vecs[2]  = '{"clamp_nine",        32'd9,          10, 1, 1'b1, 0};
        vecs[3]  = '{"held_end_three",    32'd3,          10, 5, 1'b1, 0};
        vecs[4]  = '{"edge_wins_expiry",  32'd1,          16, 1, 1'b1, 0};
        vecs[5]  = '{"timeout_silent",    32'd1,          10, 1, 1'b0, 0};
        vecs[6]  = '{"recover_after_err", 32'd2,          10, 1, 1'b1, 0};
        vecs[7]  = '{"go_during_wait",    32'd3,          10, 1, 1'b1, 17};
        vecs[8]  = '{"late_by_one",       32'd2,          17, 1, 1'b1, 0};
        vecs[9]  = '{"clamp_max_ncols",   32'hFFFF_FFFF,   3, 1, 1'b1, 0};
        vecs[10] = '{"fast_core",         32'd1,           2, 1, 1'b1, 0};

        rst = 1'b1; go = 1'b0; mat_in = '0; n_cols = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        check_int("reset:state", dbg_state, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        for (int v = 0; v < 11; v++)
            run_case(vecs[v].name, vecs[v].ncols, vecs[v].lat, vecs[v].hold,
                     vecs[v].answer, vecs[v].go_again);

        for (int r = 0; r < 6; r++)
            run_case("random", NB'($urandom_range(0, 6)), $urandom_range(2, 16),
                     $urandom_range(1, 4), 1'b1, 0);

        // asynchronous reset while waiting on column 1
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++) m_el[i][j] = $urandom;
        core_lat = 10; core_hold = 1; core_answer = 1'b1;
        @(negedge clk);
        mat_in = pack_mat(); n_cols = 32'd4; go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        check_int("mid_reset:busy_before", busy, 1);
        #1;
        rst = 1'b1;
        #1;
        check_all_zero("mid_reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        dones = 0; starts_seen = 0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #1;
            if (done) dones++;
            if (core_start) starts_seen++;
        end
        check_int("mid_reset:no_done", dones, 0);
        check_int("mid_reset:no_start", starts_seen, 0);
        prev_err = 0; last_ps = '0;

        run_case("after_reset", 32'd2, 10, 1, 1'b1, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // global time bound
    initial begin
        #400000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "time bound expired");
    end

endmodule
